// File: rtl/twos_comp_serial_ctrl.sv
// Drives a bit-serial two's complement converter from a parallel valid/ready word port.
// Optional overflow flag: define TWOS_COMP_OVF_DETECT_EN.
module twos_comp_serial_ctrl #(
    parameter int WIDTH    = 8,
    parameter int CONV_LAT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             conv_reset,
    output logic             conv_in,
    input  logic             conv_out,
    output logic             busy,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        SHIFT,
        DRAIN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] captured;
    logic [CW-1:0]    cnt;
    logic             sample;
    logic             last;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign last     = (cnt == LAST);
    assign captured = {conv_out, result[WIDTH-1:1]};

    // A registered converter shows stale output in the first SHIFT cycle.
    assign sample = (state == DRAIN) ||
                    ((state == SHIFT) && ((CONV_LAT == 0) || (cnt != '0)));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            out_data   <= '0;
            out_valid  <= 1'b0;
            conv_in    <= 1'b0;
            conv_reset <= 1'b1;
            cnt        <= '0;
            word       <= '0;
            result     <= '0;
        end else begin
            if (sample) begin
                result <= captured;
            end
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        word  <= in_data;
                        state <= CLR;
                    end
                end
                CLR: begin
                    conv_reset <= 1'b0;
                    conv_in    <= word[0];
                    word       <= word >> 1;
                    cnt        <= '0;
                    state      <= SHIFT;
                end
                SHIFT: begin
                    conv_in <= word[0];
                    word    <= word >> 1;
                    cnt     <= cnt + 1'b1;
                    if (last) begin
                        conv_in <= 1'b0;
                        if (CONV_LAT == 0) begin
                            out_data   <= captured;
                            out_valid  <= 1'b1;
                            conv_reset <= 1'b1;
                            state      <= DONE;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    out_data   <= captured;
                    out_valid  <= 1'b1;
                    conv_reset <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TWOS_COMP_OVF_DETECT_EN
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic ovf_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ovf_q <= 1'b0;
        end else if ((state == IDLE) && in_valid) begin
            ovf_q <= (in_data == MIN_NEG);
        end else if ((state == DONE) && out_ready) begin
            ovf_q <= 1'b0;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule
